// File: rtl/gauss_issue_scheduler_pkg.sv
// Shared types and constants for the Gauss issue scheduler and its arbiter.
package gauss_issue_scheduler_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN, ST_DONE} state_e;

  localparam int DEF_ADDR_W    = 5;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_RES_W     = 16;
  localparam int DEF_LAST_ADDR = 31;

  localparam logic FU0 = 1'b0;
  localparam logic FU1 = 1'b1;
endpackage

// File: rtl/gauss_rr_arbiter.sv
// Two-way grant between the Gauss units; round-robin only when both are free.
module gauss_rr_arbiter
  import gauss_issue_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       preset,
  input  logic       avail0,
  input  logic       avail1,
  input  logic       req,
  input  logic       adv,
  output logic [1:0] grant
);
  logic r_rr;
  logic w_both;

  assign w_both = avail0 & avail1;

  always_comb begin
    grant = 2'b00;
    if (req && adv) begin
      if (w_both)      grant = r_rr ? 2'b10 : 2'b01;
      else if (avail0) grant[FU0] = 1'b1;
      else if (avail1) grant[FU1] = 1'b1;
    end
  end

  // rr only moves on a contested grant, so a unit held busy does not shift the turn
  always_ff @(posedge clk or negedge preset) begin
    if (!preset)                      r_rr <= 1'b0;
    else if (req && adv && w_both)    r_rr <= ~r_rr;
  end
endmodule

// File: rtl/gauss_issue_scheduler.sv
// Scans data memory, dispatches non-zero operands to two Gauss units, and sums their results.
module gauss_issue_scheduler
  import gauss_issue_scheduler_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RES_W     = DEF_RES_W,
  parameter int LAST_ADDR = DEF_LAST_ADDR
) (
  input  logic              clk,
  input  logic              preset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              fu0_issue,
  output logic [DATA_W-1:0] fu0_operand,
  input  logic              fu0_busy,
  input  logic              fu0_res_valid,
  input  logic [RES_W-1:0]  fu0_res,
  output logic              fu1_issue,
  output logic [DATA_W-1:0] fu1_operand,
  input  logic              fu1_busy,
  input  logic              fu1_res_valid,
  input  logic [RES_W-1:0]  fu1_res,
  output logic [RES_W-1:0]  total,
  output logic              overflow,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_out0, r_out1;
  logic              r_fu0_issue, r_fu1_issue;
  logic [DATA_W-1:0] r_fu0_op, r_fu1_op;
  logic [RES_W-1:0]  r_total;
  logic              r_ovf;

  logic              w_scan, w_nz, w_avail0, w_avail1, w_step, w_last;
  logic              w_clear, w_collect, w_out0_nxt, w_out1_nxt;
  logic [1:0]        w_grant;
  logic [RES_W+1:0]  w_sum;

  assign w_scan    = (r_state == ST_SCAN);
  assign w_nz      = |mem_data;
  assign w_avail0  = ~r_out0 & ~fu0_busy;
  assign w_avail1  = ~r_out1 & ~fu1_busy;
  assign w_step    = w_scan & (~w_nz | (|w_grant));
  assign w_last    = (r_ptr == LAST);
  assign w_clear   = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_collect = (r_state != ST_IDLE);

  // set wins over clear so a same-cycle result and re-issue leaves the unit outstanding
  assign w_out0_nxt = (r_out0 & ~fu0_res_valid) | w_grant[FU0];
  assign w_out1_nxt = (r_out1 & ~fu1_res_valid) | w_grant[FU1];

  assign w_sum = (RES_W+2)'(r_total)
               + (RES_W+2)'(fu0_res_valid ? fu0_res : {RES_W{1'b0}})
               + (RES_W+2)'(fu1_res_valid ? fu1_res : {RES_W{1'b0}});

  gauss_rr_arbiter u_arb (
    .clk    (clk),
    .preset (preset),
    .avail0 (w_avail0),
    .avail1 (w_avail1),
    .req    (w_nz),
    .adv    (w_scan),
    .grant  (w_grant)
  );

  always_ff @(posedge clk or negedge preset) begin
    if (!preset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // DRAIN looks at next-cycle outstanding so done follows the last result by one cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_SCAN;
      ST_SCAN:  if (w_step && w_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!w_out0_nxt && !w_out1_nxt) w_state_nxt = ST_DONE;
      ST_DONE:  if (start) w_state_nxt = ST_SCAN;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge preset) begin
    if (!preset) begin
      r_ptr       <= '0;
      r_out0      <= 1'b0;
      r_out1      <= 1'b0;
      r_fu0_issue <= 1'b0;
      r_fu1_issue <= 1'b0;
      r_fu0_op    <= '0;
      r_fu1_op    <= '0;
      r_total     <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_fu0_issue <= w_grant[FU0];
      r_fu1_issue <= w_grant[FU1];
      if (w_grant[FU0]) r_fu0_op <= mem_data;
      if (w_grant[FU1]) r_fu1_op <= mem_data;
      if (w_clear) begin
        r_ptr   <= '0;
        r_out0  <= 1'b0;
        r_out1  <= 1'b0;
        r_total <= '0;
        r_ovf   <= 1'b0;
      end else begin
        if (w_step && !w_last) r_ptr <= r_ptr + 1'b1;
        r_out0 <= w_out0_nxt;
        r_out1 <= w_out1_nxt;
        if (w_collect) begin
          r_total <= w_sum[RES_W-1:0];
          if (|w_sum[RES_W+1:RES_W]) r_ovf <= 1'b1;
        end
      end
    end
  end

  assign mem_addr    = r_ptr;
  assign fu0_issue   = r_fu0_issue;
  assign fu1_issue   = r_fu1_issue;
  assign fu0_operand = r_fu0_op;
  assign fu1_operand = r_fu1_op;
  assign total       = r_total;
  assign overflow    = r_ovf;
  assign busy        = (r_state == ST_SCAN) | (r_state == ST_DRAIN);
  assign done        = (r_state == ST_DONE);
endmodule

// File: tb/tb_gauss_issue_scheduler.sv
// Randomized and directed bench for gauss_issue_scheduler against a cycle-level behavioural model.
module tb_gauss_issue_scheduler;
  localparam int AW = 5, DW = 16, RW = 8, LAST = 31;
  localparam int M_IDLE = 0, M_SCAN = 1, M_DRAIN = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic preset;
  logic start = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic fu0_issue, fu1_issue;
  logic [DW-1:0] fu0_operand, fu1_operand;
  logic fu0_busy = 1'b0, fu1_busy = 1'b0;
  logic fu0_res_valid = 1'b0, fu1_res_valid = 1'b0;
  logic [RW-1:0] fu0_res = '0, fu1_res = '0;
  logic [RW-1:0] total;
  logic overflow, busy, done;

  logic [DW-1:0] mem [0:LAST];
  assign mem_data = mem[mem_addr];

  always #5 clk = ~clk;

  gauss_issue_scheduler #(.ADDR_W(AW), .DATA_W(DW), .RES_W(RW), .LAST_ADDR(LAST)) dut (
    .clk(clk), .preset(preset), .start(start),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .fu0_issue(fu0_issue), .fu0_operand(fu0_operand), .fu0_busy(fu0_busy),
    .fu0_res_valid(fu0_res_valid), .fu0_res(fu0_res),
    .fu1_issue(fu1_issue), .fu1_operand(fu1_operand), .fu1_busy(fu1_busy),
    .fu1_res_valid(fu1_res_valid), .fu1_res(fu1_res),
    .total(total), .overflow(overflow), .busy(busy), .done(done)
  );

  int n_tot = 0, n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int gauss(input int n);
    return n * (n + 1) / 2;
  endfunction

  // ---------------- behavioural model ----------------
  int m_st, m_ptr, m_rr, m_total, m_ovf;
  int m_o [2];
  int m_iss [2];
  logic [DW-1:0] m_op [2];

  task automatic m_reset();
    m_st = M_IDLE; m_ptr = 0; m_rr = 0; m_total = 0; m_ovf = 0;
    for (int i = 0; i < 2; i++) begin m_o[i] = 0; m_iss[i] = 0; m_op[i] = '0; end
  endtask

  task automatic m_step();
    int g, sum;
    bit nz, a0, a1;
    g  = -1;
    nz = (m_st == M_SCAN) && (mem[m_ptr] != 0);
    if (nz) begin
      a0 = !m_o[0] && !fu0_busy;
      a1 = !m_o[1] && !fu1_busy;
      if (a0 && a1) begin g = m_rr; m_rr = 1 - m_rr; end
      else if (a0) g = 0;
      else if (a1) g = 1;
    end
    m_iss[0] = (g == 0);
    m_iss[1] = (g == 1);
    if (g >= 0) m_op[g] = mem[m_ptr];
    if (m_st != M_IDLE) begin
      sum = m_total + (fu0_res_valid ? int'(fu0_res) : 0) + (fu1_res_valid ? int'(fu1_res) : 0);
      if (sum >= 256) m_ovf = 1;
      m_total = sum % 256;
      if (fu0_res_valid) m_o[0] = 0;
      if (fu1_res_valid) m_o[1] = 0;
    end
    if (g >= 0) m_o[g] = 1;
    case (m_st)
      M_IDLE, M_DONE:
        if (start) begin
          m_st = M_SCAN; m_ptr = 0; m_total = 0; m_ovf = 0; m_o[0] = 0; m_o[1] = 0;
        end
      M_SCAN:
        if (g >= 0 || !nz) begin
          if (m_ptr == LAST) m_st = M_DRAIN;
          else m_ptr++;
        end
      M_DRAIN:
        if (m_o[0] == 0 && m_o[1] == 0) m_st = M_DONE;
      default: ;
    endcase
  endtask

  // ---------------- Gauss unit environment ----------------
  int cnt [2];
  int lat [2];
  logic [RW-1:0] val [2];
  int ovr_q [$];
  bit rnd_busy = 0, force_b1 = 0;

  task automatic env();
    fu0_res_valid = 1'b0;
    fu1_res_valid = 1'b0;
    if (cnt[0] > 0) begin cnt[0]--; if (cnt[0] == 0) begin fu0_res_valid = 1'b1; fu0_res = val[0]; end end
    if (cnt[1] > 0) begin cnt[1]--; if (cnt[1] == 0) begin fu1_res_valid = 1'b1; fu1_res = val[1]; end end
    if (fu0_issue) begin
      cnt[0] = lat[0];
      val[0] = (ovr_q.size() > 0) ? RW'(ovr_q.pop_front()) : RW'(gauss(int'(fu0_operand)));
    end
    if (fu1_issue) begin
      cnt[1] = lat[1];
      val[1] = (ovr_q.size() > 0) ? RW'(ovr_q.pop_front()) : RW'(gauss(int'(fu1_operand)));
    end
    if (rnd_busy) begin
      fu0_busy = ($urandom_range(0, 3) == 0);
      fu1_busy = ($urandom_range(0, 3) == 0);
    end
    if (force_b1) fu1_busy = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (preset) m_step();
    #1;
    env();
  endtask

  // ---------------- per-cycle compare ----------------
  int log_u [$];
  int log_op [$];

  always @(negedge clk) begin
    if (preset === 1'b1) begin
      chk("mem_addr", int'(mem_addr), m_ptr);
      chk("fu0_issue", int'(fu0_issue), m_iss[0]);
      chk("fu1_issue", int'(fu1_issue), m_iss[1]);
      chk("fu0_operand", int'(fu0_operand), int'(m_op[0]));
      chk("fu1_operand", int'(fu1_operand), int'(m_op[1]));
      chk("total", int'(total), m_total);
      chk("overflow", int'(overflow), m_ovf);
      chk("busy", int'(busy), int'(m_st == M_SCAN || m_st == M_DRAIN));
      chk("done", int'(done), int'(m_st == M_DONE));
      if (fu0_issue) begin log_u.push_back(0); log_op.push_back(int'(fu0_operand)); end
      if (fu1_issue) begin log_u.push_back(1); log_op.push_back(int'(fu1_operand)); end
    end
  end

  // ---------------- helpers ----------------
  task automatic mem_clear();
    for (int i = 0; i <= LAST; i++) mem[i] = '0;
  endtask

  task automatic kick();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit noise, output int n);
    n = 0;
    while (!done && n < budget) begin
      if (noise && busy) start = ($urandom_range(0, 5) == 0);
      cyc();
      start = 1'b0;
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int n, seen, exp_sum, u1cnt;
    preset = 1'b0;
    mem_clear();
    lat[0] = 2; lat[1] = 2; cnt[0] = 0; cnt[1] = 0;
    m_reset();
    repeat (2) cyc();
    preset = 1'b1;
    cyc();

    // reset mid-scan with unit 0 outstanding
    mem[4] = 16'd7; mem[5] = 16'd8;
    force_b1 = 1; fu1_busy = 1'b1; lat[0] = 10;
    kick();
    repeat (6) cyc();
    chk("pre_reset_ptr", m_ptr, 5);
    chk("pre_reset_out0", m_o[0], 1);
    preset = 1'b0;
    m_reset();
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_total", int'(total), 0);
    chk("rst_issue0", int'(fu0_issue), 0);
    chk("rst_issue1", int'(fu1_issue), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_addr", int'(mem_addr), 0);
    preset = 1'b1;
    force_b1 = 0; fu1_busy = 1'b0;
    seen = 0;
    for (int k = 0; k < 14; k++) begin cyc(); if (fu0_res_valid) seen = 1; end
    chk("late_result_seen", seen, 1);
    chk("late_result_ignored", int'(total), 0);
    lat[0] = 2;

    // {3,4,0,5}: rr to fu0, then fu1, stall, then fu0
    mem_clear();
    mem[0] = 16'd3; mem[1] = 16'd4; mem[2] = 16'd0; mem[3] = 16'd5;
    log_u.delete(); log_op.delete();
    kick();
    wait_done(200, 0, n);
    chk("seq_count", log_u.size(), 3);
    if (log_u.size() == 3) begin
      chk("seq_u0", log_u[0], 0); chk("seq_op0", log_op[0], 3);
      chk("seq_u1", log_u[1], 1); chk("seq_op1", log_op[1], 4);
      chk("seq_u2", log_u[2], 0); chk("seq_op2", log_op[2], 5);
    end
    chk("seq_total", int'(total), 31);
    chk("seq_ovf", int'(overflow), 0);
    chk("seq_done", int'(done), 1);

    // all-zero scan
    mem_clear();
    log_u.delete(); log_op.delete();
    kick();
    wait_done(100, 0, n);
    chk("zero_cycles", n, 33);
    chk("zero_total", int'(total), 0);
    chk("zero_issues", log_u.size(), 0);

    // both units report in the same cycle: 10 + 21
    mem_clear();
    mem[0] = 16'd4; mem[1] = 16'd6;
    if (m_rr == 0) begin lat[0] = 3; lat[1] = 2; end
    else           begin lat[0] = 2; lat[1] = 3; end
    kick();
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      cyc();
      if (fu0_res_valid && fu1_res_valid) seen = 1;
    end
    chk("both_seen", seen, 1);
    chk("both_before", int'(total), 0);
    cyc();
    chk("both_sum", int'(total), 31);
    chk("both_out_clear", m_o[0] + m_o[1], 0);
    wait_done(100, 0, n);
    lat[0] = 2; lat[1] = 2;

    // 200 + 100 wraps an 8-bit total
    mem_clear();
    mem[0] = 16'd1; mem[1] = 16'd2;
    ovr_q.push_back(200); ovr_q.push_back(100);
    kick();
    wait_done(100, 0, n);
    chk("ovf_total", int'(total), 44);
    chk("ovf_flag", int'(overflow), 1);
    repeat (3) cyc();
    chk("ovf_sticky", int'(overflow), 1);
    mem_clear();
    kick();
    chk("ovf_cleared", int'(overflow), 0);
    chk("ovf_total_cleared", int'(total), 0);
    wait_done(100, 0, n);

    // fu1 held busy: everything lands on fu0
    mem_clear();
    mem[0] = 16'd1; mem[1] = 16'd2; mem[2] = 16'd3;
    force_b1 = 1; fu1_busy = 1'b1;
    log_u.delete(); log_op.delete();
    kick();
    wait_done(200, 0, n);
    u1cnt = 0;
    foreach (log_u[i]) u1cnt += log_u[i];
    chk("b1_count", log_u.size(), 3);
    chk("b1_none_on_fu1", u1cnt, 0);
    chk("b1_total", int'(total), 10);
    force_b1 = 0; fu1_busy = 1'b0;
    mem_clear();
    mem[0] = 16'd5; mem[1] = 16'd6; mem[2] = 16'd7;
    kick();
    wait_done(200, 0, n);
    chk("b1_release_total", int'(total), (15 + 21 + 28) % 256);

    // randomized scans with random busy, latency and ignored starts
    rnd_busy = 1;
    for (int it = 0; it < 10; it++) begin
      exp_sum = 0;
      for (int a = 0; a <= LAST; a++) begin
        mem[a] = ($urandom_range(0, 2) == 0) ? 16'd0 : DW'($urandom_range(1, 30));
        if (mem[a] != 0) exp_sum += gauss(int'(mem[a])) % 256;
      end
      lat[0] = $urandom_range(1, 4);
      lat[1] = $urandom_range(1, 4);
      kick();
      wait_done(2000, 1, n);
      chk("rnd_total", int'(total), exp_sum % 256);
      chk("rnd_ovf", int'(overflow), int'(exp_sum >= 256));
    end
    rnd_busy = 0; fu0_busy = 1'b0; fu1_busy = 1'b0;
    repeat (2) cyc();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/gauss_issue_scheduler.md
Name: gauss_issue_scheduler

Overview:
- Sequencer and arbiter for the two Gauss functional units.
- Walks the data memory from address 0 to LAST_ADDR and skips zero entries. Each non-zero operand goes to whichever unit is free; when both are free, round-robin decides.
- Accumulates both units' results into one total and flags completion.
- Sits between the data memory and the Gauss unit pair. It replaces the ad-hoc fetch/dispatch control.

Parameters:
- ADDR_W, 5, data memory address width
- DATA_W, 16, operand width
- RES_W, 16, result and total width
- LAST_ADDR, 31, final memory address scanned (must be at most 2^ADDR_W-1)

Ports:
- clk  in  1  system clock, rising edge
- preset  in  1  asynchronous, active-low reset
- start  in  1  begin a scan; sampled only in IDLE or DONE
- mem_addr  out  ADDR_W  data memory read address (combinational read)
- mem_data  in  DATA_W  word at mem_addr, same cycle
- fu0_issue  out  1  one-cycle pulse: fu0_operand is valid for unit 0
- fu0_operand  out  DATA_W  operand for unit 0
- fu0_busy  in  1  unit 0 reports it is occupied
- fu0_res_valid  in  1  one-cycle pulse: fu0_res is valid
- fu0_res  in  RES_W  unit 0 result n(n+1)/2
- fu1_issue, fu1_operand, fu1_busy, fu1_res_valid, fu1_res  same as unit 0, for unit 1
- total  out  RES_W  sum of all results, modulo 2^RES_W
- overflow  out  1  sticky: total wrapped during this scan
- busy  out  1  high in SCAN and DRAIN
- done  out  1  high in DONE; held until the next accepted start

Behaviour:
Reset (preset=0, asynchronous):
- State goes to IDLE; ptr=0; rr=0; out0=out1=0.
- total=0, overflow=0, done=0, busy=0, issue strobes 0, operands 0.

States:
- IDLE: start=1 → SCAN; ptr, total and overflow are cleared.
- SCAN: mem_addr=ptr. Each cycle exactly one of:
  - mem_data==0: skip; ptr++.
  - Non-zero and at least one unit available (avail_i = ~out_i & ~fuI_busy):
    - Issue to the available unit. If both are available, issue to unit rr, then toggle rr.
    - Raise fuI_issue for one cycle with fuI_operand=mem_data; set out_i; ptr++.
  - Non-zero and neither unit available: stall; ptr holds; no issue.
  - When the element at ptr==LAST_ADDR is skipped or issued → DRAIN. ptr does not wrap.
- DRAIN: wait until out0==0 and out1==0 → DONE.
- DONE: done=1; total is stable. start=1 → SCAN with everything cleared; done drops the same cycle.

Other rules:
- start in SCAN or DRAIN is ignored.
- At most one issue per cycle; the two units are never issued in the same cycle.
- Result collection runs in every state except IDLE:
  - fuI_res_valid clears out_i and adds fuI_res to total.
  - If both units report in the same cycle: total += fu0_res + fu1_res in that cycle, and overflow is set on any carry out of RES_W.
  - Result and new issue on the same unit in the same cycle: the result is accumulated and out_i stays set.
  - A result pulse with out_i==0 is still accumulated (no filtering).
- Latency:
  - Issue is combinational from mem_data to a registered strobe; the strobe is visible one cycle after the SCAN cycle that selected it.
  - done rises one cycle after the last outstanding result is seen.
  - Scanning all zeros takes LAST_ADDR+1 SCAN cycles, then 1 DRAIN cycle, then DONE.
- Reset mid-operation aborts everything. Pending results arriving after reset are ignored while in IDLE.

Decomposition:
- Shared package: state encoding (IDLE, SCAN, DRAIN, DONE), default widths, and unit index constants FU0=0, FU1=1.
- One sub-module is natural: gauss_rr_arbiter.
  - Inputs: avail0, avail1, req, and an advance qualifier.
  - Outputs: one-hot grant[1:0]; it owns the rr flop.

Test Plan:
- Reset mid-SCAN (ptr=5, out0=1) → immediately IDLE; busy=0, total=0, issue strobes 0; a later fu0_res_valid has no effect.
- LAST_ADDR=3, memory {3,4,0,5}, units respond 2 cycles after issue:
  - Issues go 3→fu0, 4→fu1, 5→fu0 after a stall.
  - total=6+10+15=31, done=1, overflow=0.
- All-zero memory, LAST_ADDR=31 → no issue strobes ever; done after 33 cycles; total=0.
- Both units complete in the same cycle with results 10 and 21 → total increases by 31 in one cycle; out0 and out1 both clear.
- RES_W=8, results 200 and 100 → total=44, overflow=1. overflow stays set until the next start.
- fu1_busy held high externally → every operand goes to fu0, with SCAN stalling between issues. Releasing fu1_busy restores round-robin starting from the current rr value.
